sqrt_sched: RTL and testbench

Round-robin scheduler that shares one iterative bisection square-root engine (`sqrt` datapath: N and DELTA in, 64-bit root out) between NREQ requesters. It accepts one operand pair at a time and starts the engine. It waits for completion, then returns the root with the requester ID over a valid/ready response port. Trivial and illegal operands are resolved locally and never occupy the engine.

---
 rtl/sqrt_sched.sv | 165 ++++++++++++++++
 tb/tb_sqrt_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_sched.sv
// sqrt_sched: round-robin front end for one shared iterative square-root engine.
//
// Up to NREQ requesters present (N, DELTA) operand pairs. A single request is
// accepted at a time. Trivial (N<=1) and illegal (DELTA==0) operands are
// answered locally. All other requests launch the engine and wait for it to
// finish. Results are returned on a valid/ready response port, tagged with
// the requester index.
//
// Optional feature macro: SQRT_SCHED_TIMEOUT_EN. When it is defined, a
// request is aborted with RSP_ERR=1 if the engine stays in WAIT for TIMEOUT
// cycles without signalling completion.
//
// Ports
//   CLK, RESET              clock (rising edge), synchronous active-high reset
//   REQ_VALID/REQ_READY     per-requester handshake; READY is one-hot, IDLE only
//   REQ_N/REQ_DELTA         packed operands, requester i at [32i+31:32i]
//   ENG_START               one-cycle launch pulse to the engine
//   ENG_N/ENG_DELTA         latched operands, held from LAUNCH through WAIT
//   ENG_DONE/ENG_ROOT       engine completion pulse and its result
//   RSP_VALID/RSP_READY     response handshake
//   RSP_ID/RSP_ROOT/RSP_ERR response payload, stable while RSP_VALID is high
//   BUSY                    high whenever the scheduler is not IDLE
module sqrt_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NREQ-1:0]         REQ_VALID,
  output logic [NREQ-1:0]         REQ_READY,
  input  logic [NREQ*32-1:0]      REQ_N,
  input  logic [NREQ*32-1:0]      REQ_DELTA,
  output logic                    ENG_START,
  output logic [31:0]             ENG_N,
  output logic [31:0]             ENG_DELTA,
  input  logic                    ENG_DONE,
  input  logic [63:0]             ENG_ROOT,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [$clog2(NREQ)-1:0] RSP_ID,
  output logic [63:0]             RSP_ROOT,
  output logic                    RSP_ERR,
  output logic                    BUSY
);
  localparam int IDW = $clog2(NREQ);

  // Catch unsupported configurations at elaboration time.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("sqrt_sched: NREQ must be 2..8 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           win_vld;
  logic [IDW:0]   sum;
  logic [31:0]    sel_n, sel_d;

  // Round-robin search starting at ptr. The loop runs from the farthest
  // offset down to offset 0, so the closest requester at or above ptr is the
  // last one to be written and therefore wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    sum     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (REQ_VALID[sum[IDW-1:0]]) begin
        win_vld = 1'b1;
        win     = sum[IDW-1:0];
      end
    end
  end

  assign sel_n = REQ_N[win*32 +: 32];
  assign sel_d = REQ_DELTA[win*32 +: 32];

  for (genvar i = 0; i < NREQ; i++) begin : g_grant
    assign REQ_READY[i] = (state == IDLE) && !RESET && win_vld && (win == IDW'(i));
  end

  assign BUSY = (state != IDLE);

`ifdef SQRT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      ptr       <= '0;
      ENG_START <= 1'b0;
      ENG_N     <= '0;
      ENG_DELTA <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_ROOT  <= '0;
      RSP_ERR   <= 1'b0;
`ifdef SQRT_SCHED_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          ENG_N     <= sel_n;
          ENG_DELTA <= sel_d;
          RSP_ID    <= win;
          ptr       <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
          if (sel_d == '0) begin
            // A zero step can never converge: reject without the engine.
            RSP_ROOT  <= '0;
            RSP_ERR   <= 1'b1;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else if (sel_n <= 32'd1) begin
            // sqrt(0)=0 and sqrt(1)=1, so the root is N itself.
            RSP_ROOT  <= {32'b0, sel_n};
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else begin
            ENG_START <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          ENG_START <= 1'b0;
          state     <= WAIT;
`ifdef SQRT_SCHED_TIMEOUT_EN
          cnt       <= '0;
`endif
        end
        WAIT: begin
          // ENG_DONE has priority, so a result that arrives on the
          // expiry cycle is still delivered.
          if (ENG_DONE) begin
            RSP_ROOT  <= ENG_ROOT;
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end
`ifdef SQRT_SCHED_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT-1)) begin
            RSP_ROOT  <= '0;
            RSP_ERR   <= 1'b1;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: if (RSP_READY) begin
          RSP_VALID <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_sched.sv
// Scoreboard bench for sqrt_sched. The stimulus pushes hand-computed
// responses into a queue, and a monitor pops and compares them on every
// response handshake. A behavioural engine answers ENG_START after eng_lat
// cycles.
module tb_sqrt_sched;
  localparam int NREQ = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ*32-1:0] REQ_N, REQ_DELTA;
  logic              ENG_START;
  logic [31:0]       ENG_N, ENG_DELTA;
  logic              ENG_DONE;
  logic [63:0]       ENG_ROOT;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [1:0]        RSP_ID;
  logic [63:0]       RSP_ROOT;
  logic              RSP_ERR;
  logic              BUSY;

  sqrt_sched #(.NREQ(NREQ), .TIMEOUT(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_N(REQ_N), .REQ_DELTA(REQ_DELTA),
    .ENG_START(ENG_START), .ENG_N(ENG_N), .ENG_DELTA(ENG_DELTA),
    .ENG_DONE(ENG_DONE), .ENG_ROOT(ENG_ROOT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_ID(RSP_ID), .RSP_ROOT(RSP_ROOT), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int id; logic [63:0] root; logic err; } rsp_t;
  rsp_t sb[$];

  int checks = 0, failures = 0;
  int starts = 0;
  bit eng_auto = 1'b1;
  int eng_lat  = 5;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [63:0] isqrt(logic [31:0] n);
    logic [63:0] r = 0;
    while ((r+1)*(r+1) <= {32'b0, n}) r++;
    return r;
  endfunction

  // Response monitor / scoreboard.
  always @(negedge CLK) begin
    if (!RESET && RSP_VALID && RSP_READY) begin
      if (sb.size() == 0) fail_now("unexpected_rsp");
      else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_id",   {62'b0, RSP_ID}, 64'(e.id));
        chk("rsp_root", RSP_ROOT, e.root);
        chk("rsp_err",  {63'b0, RSP_ERR}, {63'b0, e.err});
      end
    end
  end

  always @(negedge CLK) if (ENG_START) starts <= starts + 1;

  // Behavioural engine.
  initial begin
    logic [31:0] en_n;
    ENG_DONE = 1'b0;
    ENG_ROOT = '0;
    forever begin
      @(negedge CLK);
      if (ENG_START && eng_auto) begin
        en_n = ENG_N;
        repeat (eng_lat) @(posedge CLK);
        #1 ENG_DONE = 1'b1; ENG_ROOT = isqrt(en_n);
        @(posedge CLK);
        #1 ENG_DONE = 1'b0; ENG_ROOT = '0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(int n);
    RESET = 1'b1;
    repeat (n) tick();
    RESET = 1'b0;
  endtask

  task automatic set_req(int id, logic [31:0] n, logic [31:0] d);
    REQ_N[id*32 +: 32]     = n;
    REQ_DELTA[id*32 +: 32] = d;
  endtask

  // Returns at the negedge of the accept cycle; t is that cycle number.
  task automatic wait_grant(int id, output int t);
    bit ok = 0;
    t = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (REQ_READY[id] && REQ_VALID[id]) begin ok = 1; t = cyc; break; end
    end
    if (!ok) fail_now($sformatf("grant_timeout_req%0d", id));
  endtask

  task automatic issue(int id, logic [31:0] n, logic [31:0] d, output int t);
    set_req(id, n, d);
    REQ_VALID[id] = 1'b1;
    wait_grant(id, t);
    tick();
    REQ_VALID[id] = 1'b0;
  endtask

  task automatic wait_rsp_valid(int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK);
      if (RSP_VALID) begin ok = 1; break; end
    end
    if (!ok) fail_now("rsp_valid_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(negedge CLK); #1;
    end
    if (sb.size() != 0) fail_now("scoreboard_not_drained");
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s0, g, k;
    int order[5] = '{0, 1, 2, 3, 0};
    bit ok;

    RESET = 1'b1; REQ_VALID = '0; REQ_N = '0; REQ_DELTA = '0; RSP_READY = 1'b1;

    // Reset state.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", {60'b0, REQ_READY}, 0);
    chk("rst_eng_start", {63'b0, ENG_START}, 0);
    chk("rst_eng_n",     {32'b0, ENG_N}, 0);
    chk("rst_eng_delta", {32'b0, ENG_DELTA}, 0);
    chk("rst_rsp_valid", {63'b0, RSP_VALID}, 0);
    chk("rst_rsp_id",    {62'b0, RSP_ID}, 0);
    chk("rst_rsp_root",  RSP_ROOT, 0);
    chk("rst_rsp_err",   {63'b0, RSP_ERR}, 0);
    chk("rst_busy",      {63'b0, BUSY}, 0);
    @(posedge CLK); #1 RESET = 1'b0;
    tick();

    // Single request through the engine: 16 -> 4.
    sb.push_back('{2, 64'd4, 1'b0});
    issue(2, 32'd16, 32'd8, t);
    @(negedge CLK);
    chk("launch_start", {63'b0, ENG_START}, 1);
    chk("launch_eng_n", {32'b0, ENG_N}, 16);
    @(negedge CLK);
    chk("start_one_cycle", {63'b0, ENG_START}, 0);
    wait_rsp_valid(50);
    chk("rsp_latency", 64'(cyc), 64'(t + 7));
    drain();

    // Fairness: all valid from a cleared pointer.
    do_reset(2);
    sb.push_back('{0, 64'd0,  1'b0});
    sb.push_back('{1, 64'd1,  1'b0});
    sb.push_back('{2, 64'd10, 1'b0});
    sb.push_back('{3, 64'd7,  1'b0});
    sb.push_back('{0, 64'd0,  1'b0});
    set_req(0, 32'd0, 32'd1);
    set_req(1, 32'd1, 32'd1);
    set_req(2, 32'd100, 32'd64);
    set_req(3, 32'd49, 32'd32);
    REQ_VALID = '1;
    k = 0;
    for (int i = 0; i < 400 && k < 5; i++) begin
      @(negedge CLK);
      if (|(REQ_READY & REQ_VALID)) begin
        g = 0;
        for (int j = 0; j < NREQ; j++) if (REQ_READY[j]) g = j;
        chk("grant_onehot", 64'($countones(REQ_READY)), 1);
        chk($sformatf("grant_order_%0d", k), 64'(g), 64'(order[k]));
        k++;
        if (k == 5) begin @(posedge CLK); #1 REQ_VALID = '0; end
      end
    end
    if (k != 5) begin REQ_VALID = '0; fail_now("fairness_grants_missing"); end
    drain();

    // Local resolve: N<=1, then DELTA==0.
    sb.push_back('{1, 64'd1, 1'b0});
    s0 = starts;
    issue(1, 32'd1, 32'd4, t);
    @(negedge CLK);
    chk("local_rsp_next_cycle", {63'b0, RSP_VALID}, 1);
    drain();
    chk("local_no_start", 64'(starts), 64'(s0));
    sb.push_back('{3, 64'd0, 1'b1});
    s0 = starts;
    issue(3, 32'd9, 32'd0, t);
    @(negedge CLK);
    chk("zero_delta_rsp", {63'b0, RSP_VALID}, 1);
    chk("zero_delta_err", {63'b0, RSP_ERR}, 1);
    drain();
    chk("zero_delta_no_start", 64'(starts), 64'(s0));

    // Backpressure: response held for 10 cycles while requester 1 waits.
    RSP_READY = 1'b0;
    sb.push_back('{0, 64'd6, 1'b0});
    sb.push_back('{1, 64'd2, 1'b0});
    set_req(0, 32'd36, 32'd16);
    set_req(1, 32'd4, 32'd2);
    REQ_VALID = 4'b0011;
    wait_grant(0, t);
    tick();
    REQ_VALID[0] = 1'b0;
    wait_rsp_valid(50);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {63'b0, RSP_VALID}, 1);
      chk("bp_root",  RSP_ROOT, 6);
      chk("bp_id",    {62'b0, RSP_ID}, 0);
      chk("bp_err",   {63'b0, RSP_ERR}, 0);
      chk("bp_req_ready", {60'b0, REQ_READY}, 0);
      @(negedge CLK);
    end
    @(posedge CLK); #1 RSP_READY = 1'b1;
    wait_grant(1, t);
    tick();
    REQ_VALID[1] = 1'b0;
    drain();

    // Reset during WAIT, then a late ENG_DONE.
    eng_auto = 1'b0;
    issue(2, 32'd64, 32'd8, t);
    tick();
    tick();
    do_reset(1);
    ENG_DONE = 1'b1; ENG_ROOT = 64'd8;
    tick();
    ENG_DONE = 1'b0; ENG_ROOT = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("post_reset_no_rsp", {63'b0, RSP_VALID}, 0);
    end
    chk("post_reset_idle", {63'b0, BUSY}, 0);
    eng_auto = 1'b1;
    tick();
    sb.push_back('{0, 64'd0, 1'b0});
    sb.push_back('{3, 64'd1, 1'b0});
    set_req(0, 32'd0, 32'd1);
    set_req(3, 32'd1, 32'd1);
    REQ_VALID = 4'b1001;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (|(REQ_READY & REQ_VALID)) begin ok = 1; break; end
    end
    if (!ok) fail_now("post_reset_grant_timeout");
    else chk("post_reset_first_grant", {60'b0, REQ_READY}, 64'b0001);
    @(posedge CLK); #1 REQ_VALID[0] = 1'b0;
    wait_grant(3, t);
    tick();
    REQ_VALID[3] = 1'b0;
    drain();

    // Engine that never finishes.
    eng_auto = 1'b0;
`ifdef SQRT_SCHED_TIMEOUT_EN
    sb.push_back('{1, 64'd0, 1'b1});
    issue(1, 32'd81, 32'd4, t);
    wait_rsp_valid(200);
    chk("timeout_latency", 64'(cyc), 64'(t + 1 + 65));
    drain();
`else
    issue(1, 32'd81, 32'd4, t);
    repeat (1000) tick();
    @(negedge CLK);
    chk("no_timeout_busy", {63'b0, BUSY}, 1);
    chk("no_timeout_no_rsp", {63'b0, RSP_VALID}, 0);
    tick();
    do_reset(1);
`endif
    eng_auto = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
